// File: rtl/udp_reg_responder_if.sv
// Register-ring word bundle: one ring hop between two nodes.
// Latency: none, wiring only.
// Backpressure: none; the ring carries one word per cycle.
interface udp_reg_responder_if #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int REG_ADDR_WIDTH    = 23,
  parameter int REG_DATA_WIDTH    = 32
);
  logic                         reg_req;
  logic                         reg_ack;
  logic                         reg_rd_wr_L;
  logic [REG_ADDR_WIDTH-1:0]    reg_addr;
  logic [REG_DATA_WIDTH-1:0]    reg_data;
  logic [UDP_REG_SRC_WIDTH-1:0] reg_src;

  modport master (
    output reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src
  );

  modport slave (
    input reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src
  );
endinterface

// File: rtl/udp_reg_responder.sv
// Register-ring responder: claims its block tag, serves event counters and software registers, forwards the rest.
// Latency: every ring field is registered, 1 cycle input to output.
// Backpressure: none, one ring word per cycle; define UDP_REG_RESPONDER_CLR_ON_READ_EN for clear-on-read counters.
module udp_reg_responder #(
  parameter int                        UDP_REG_SRC_WIDTH = 2,
  parameter int                        REG_ADDR_WIDTH    = 23,
  parameter int                        REG_DATA_WIDTH    = 32,
  parameter int                        TAG_WIDTH         = 17,
  parameter int                        TAG               = 0,
  parameter int                        NUM_COUNTERS      = 4,
  parameter int                        NUM_SW_REGS       = 4,
  parameter logic [REG_DATA_WIDTH-1:0] SW_REG_RESET      = '0,
  parameter logic [REG_DATA_WIDTH-1:0] CNT_RESET         = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  udp_reg_responder_if.slave                     upstream,
  udp_reg_responder_if.master                    downstream,
  input  logic [NUM_COUNTERS-1:0]                counter_inc,
  output logic [NUM_SW_REGS*REG_DATA_WIDTH-1:0]  sw_regs
);
  localparam int                        IDX_WIDTH = REG_ADDR_WIDTH - TAG_WIDTH;
  localparam logic [REG_DATA_WIDTH-1:0] NO_REG    = REG_DATA_WIDTH'(32'hDEAD_BEEF);

  logic [IDX_WIDTH-1:0]      idx;
  logic                      claim;
  logic                      rd_claim;
  logic                      wr_claim;
  logic [REG_DATA_WIDTH-1:0] cnt_q [NUM_COUNTERS];
  logic [REG_DATA_WIDTH-1:0] sw_q  [NUM_SW_REGS];
  logic [REG_DATA_WIDTH-1:0] rd_data;
  logic [NUM_COUNTERS-1:0]   cnt_clr;
  logic [NUM_SW_REGS-1:0]    sw_wr;

  assign idx      = upstream.reg_addr[IDX_WIDTH-1:0];
  assign claim    = upstream.reg_req && !upstream.reg_ack &&
                    (upstream.reg_addr[REG_ADDR_WIDTH-1 -: TAG_WIDTH] == TAG_WIDTH'(TAG));
  assign rd_claim = claim && upstream.reg_rd_wr_L;
  assign wr_claim = claim && !upstream.reg_rd_wr_L;

  // Counters sit below the software registers in the index space; anything else reads as a poison word.
  always_comb begin
    rd_data = NO_REG;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (idx == IDX_WIDTH'(i)) rd_data = cnt_q[i];
    end
    for (int j = 0; j < NUM_SW_REGS; j++) begin
      if (idx == IDX_WIDTH'(NUM_COUNTERS + j)) rd_data = sw_q[j];
    end
  end

  always_comb begin
    sw_wr = '0;
    for (int j = 0; j < NUM_SW_REGS; j++) begin
      sw_wr[j] = wr_claim && (idx == IDX_WIDTH'(NUM_COUNTERS + j));
    end
  end

  always_comb begin
    cnt_clr = '0;
`ifdef UDP_REG_RESPONDER_CLR_ON_READ_EN
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cnt_clr[i] = rd_claim && (idx == IDX_WIDTH'(i));
    end
`endif
  end

  // A clear that coincides with an event leaves the count at 1 so the event is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COUNTERS; i++) cnt_q[i] <= CNT_RESET;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (cnt_clr[i])          cnt_q[i] <= REG_DATA_WIDTH'(counter_inc[i]);
        else if (counter_inc[i]) cnt_q[i] <= cnt_q[i] + REG_DATA_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_SW_REGS; j++) sw_q[j] <= SW_REG_RESET;
    end else begin
      for (int j = 0; j < NUM_SW_REGS; j++) begin
        if (sw_wr[j]) sw_q[j] <= upstream.reg_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      downstream.reg_req     <= 1'b0;
      downstream.reg_ack     <= 1'b0;
      downstream.reg_rd_wr_L <= 1'b0;
      downstream.reg_addr    <= '0;
      downstream.reg_data    <= '0;
      downstream.reg_src     <= '0;
    end else begin
      downstream.reg_req     <= upstream.reg_req;
      downstream.reg_ack     <= upstream.reg_ack || claim;
      downstream.reg_rd_wr_L <= upstream.reg_rd_wr_L;
      downstream.reg_addr    <= upstream.reg_addr;
      downstream.reg_data    <= rd_claim ? rd_data : upstream.reg_data;
      downstream.reg_src     <= upstream.reg_src;
    end
  end

  for (genvar k = 0; k < NUM_SW_REGS; k++) begin : g_sw_out
    assign sw_regs[k*REG_DATA_WIDTH +: REG_DATA_WIDTH] = sw_q[k];
  end
endmodule

// File: tb/tb_udp_reg_responder.sv
// Directed bench for udp_reg_responder: ring words scoreboarded one cycle after they are driven.
`timescale 1ns/1ps
module tb_udp_reg_responder;
  typedef struct packed {
    logic        req;
    logic        ack;
    logic        rd;
    logic [22:0] addr;
    logic [31:0] data;
    logic [1:0]  src;
  } ring_t;

`ifdef UDP_REG_RESPONDER_CLR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   counter_inc = '0;
  logic [3:0]   wrap_inc = '0;
  logic [127:0] sw_regs;
  logic [127:0] wrap_sw;
  int           checks = 0;
  int           fails = 0;
  ring_t        sb[$];

  udp_reg_responder_if rin ();
  udp_reg_responder_if rout ();
  udp_reg_responder_if win ();
  udp_reg_responder_if wout ();

  udp_reg_responder dut (
    .clk(clk), .reset(reset), .upstream(rin), .downstream(rout),
    .counter_inc(counter_inc), .sw_regs(sw_regs)
  );

  udp_reg_responder #(.CNT_RESET(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .reset(reset), .upstream(win), .downstream(wout),
    .counter_inc(wrap_inc), .sw_regs(wrap_sw)
  );

  always #5 clk = ~clk;

  function automatic ring_t obs_ring();
    return '{rout.reg_req, rout.reg_ack, rout.reg_rd_wr_L, rout.reg_addr, rout.reg_data, rout.reg_src};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one ring word, queue the expected downstream word, compare it one cycle later.
  task automatic cyc(input string tag, input logic req, input logic ack, input logic rd,
                     input logic [22:0] addr, input logic [31:0] data, input logic [1:0] src,
                     input logic [3:0] inc, input logic claim, input logic [31:0] rdat);
    ring_t e;
    rin.reg_req = req; rin.reg_ack = ack; rin.reg_rd_wr_L = rd;
    rin.reg_addr = addr; rin.reg_data = data; rin.reg_src = src;
    counter_inc = inc;
    sb.push_back('{req, ack | claim, rd, addr, (claim && rd) ? rdat : data, src});
    @(negedge clk);
    e = sb.pop_front();
    check(tag, 128'(obs_ring()), 128'(e));
  endtask

  task automatic rd(input string tag, input int idx, input logic [3:0] inc, input logic [31:0] exp);
    cyc(tag, 1'b1, 1'b0, 1'b1, 23'(idx), 32'h1111_1111, 2'd3, inc, 1'b1, exp);
  endtask

  task automatic wr(input string tag, input int idx, input logic [31:0] data);
    cyc(tag, 1'b1, 1'b0, 1'b0, 23'(idx), data, 2'd1, 4'b0000, 1'b1, 32'h0);
  endtask

  task automatic idle(input string tag, input logic [3:0] inc);
    cyc(tag, 1'b0, 1'b0, 1'b0, 23'h0, 32'h0, 2'd0, inc, 1'b0, 32'h0);
  endtask

  initial begin
    rin.reg_req = 0; rin.reg_ack = 0; rin.reg_rd_wr_L = 0; rin.reg_addr = 0; rin.reg_data = 0; rin.reg_src = 0;
    win.reg_req = 0; win.reg_ack = 0; win.reg_rd_wr_L = 0; win.reg_addr = 0; win.reg_data = 0; win.reg_src = 0;
    repeat (2) @(negedge clk);
    check("reset_ring", 128'(obs_ring()), 128'h0);
    check("reset_sw", sw_regs, 128'h0);
    check("reset_sw_wrap", wrap_sw, 128'h0);
    reset = 1'b0;

    rd("rd_cnt0_after_reset", 0, 4'b0000, 32'h0);
    wr("wr_sw0", 4, 32'h1234_5678);
    check("sw0_one_cycle_after_wr", 128'(sw_regs[31:0]), 128'h1234_5678);
    rd("rd_sw0", 4, 4'b0000, 32'h1234_5678);

    repeat (5) idle("idle_inc2", 4'b0100);
    rd("rd_cnt2_five", 2, 4'b0000, 32'd5);
    rd("rd_cnt2_again", 2, 4'b0000, CLR ? 32'd0 : 32'd5);
    rd("rd_cnt2_with_inc", 2, 4'b0100, CLR ? 32'd0 : 32'd5);
    rd("rd_cnt2_after_inc", 2, 4'b0000, CLR ? 32'd1 : 32'd6);

    cyc("fwd_tag_mismatch", 1'b1, 1'b0, 1'b0, 23'h44, 32'hAAAA_5555, 2'd2, 4'b0000, 1'b0, 32'h0);
    cyc("fwd_acked_wr", 1'b1, 1'b1, 1'b0, 23'h4, 32'hCAFE_0000, 2'd1, 4'b0000, 1'b0, 32'h0);
    cyc("fwd_acked_rd", 1'b1, 1'b1, 1'b1, 23'h0, 32'hCAFE_0000, 2'd3, 4'b0000, 1'b0, 32'h0);
    cyc("fwd_no_req", 1'b0, 1'b0, 1'b0, 23'h4, 32'h0BAD_F00D, 2'd2, 4'b0000, 1'b0, 32'h0);
    check("sw0_untouched_by_fwd", 128'(sw_regs[31:0]), 128'h1234_5678);

    rd("rd_out_of_range_8", 8, 4'b0000, 32'hDEAD_BEEF);
    rd("rd_out_of_range_63", 63, 4'b0000, 32'hDEAD_BEEF);
    wr("wr_cnt1_ignored", 1, 32'h5555_AAAA);
    rd("rd_cnt1_unchanged", 1, 4'b0000, 32'h0);

    wr("wr_sw3", 7, 32'hA5A5_0007);
    rd("rd_sw3_back_to_back", 7, 4'b0000, 32'hA5A5_0007);
    check("sw3_value", 128'(sw_regs[127:96]), 128'hA5A5_0007);
    check("sw_all", sw_regs, {32'hA5A5_0007, 32'h0, 32'h0, 32'h1234_5678});

    // Wrap instance starts at FFFF_FFFE: two events take it through FFFF_FFFF to 0.
    wrap_inc = 4'b0001;
    repeat (2) @(negedge clk);
    wrap_inc = 4'b0000;
    win.reg_req = 1'b1; win.reg_rd_wr_L = 1'b1; win.reg_addr = 23'h0; win.reg_src = 2'd2;
    @(negedge clk);
    check("wrap_rd_cnt0", 128'({wout.reg_ack, wout.reg_data}), 128'({1'b1, 32'h0}));
    win.reg_req = 1'b0;

    rin.reg_req = 1'b1; rin.reg_ack = 1'b0; rin.reg_rd_wr_L = 1'b1; rin.reg_addr = 23'h4; rin.reg_src = 2'd1;
    @(posedge clk);
    #2;
    check("pre_reset_ack", 128'(rout.reg_ack), 128'h1);
    reset = 1'b1;
    #1;
    check("async_reset_ring", 128'(obs_ring()), 128'h0);
    check("async_reset_sw", sw_regs, 128'h0);
    @(negedge clk);
    check("reset_held_ring", 128'(obs_ring()), 128'h0);
    reset = 1'b0;
    rd("rd_sw0_post_reset", 4, 4'b0000, 32'h0);
    rd("rd_cnt2_post_reset", 2, 4'b0000, 32'h0);
    idle("idle_tail", 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/udp_reg_responder.md
Name: udp_reg_responder

Overview:
- Register-ring responder node: the far end of the register ring driven by the UDP register master.
- Sits in series on the ring between pipeline stages. Claims requests addressed to its block tag, answers reads and writes, and forwards all other traffic unchanged.
- Holds software read/write registers and hardware event counters that datapath modules use for configuration and statistics.

Parameters:
- UDP_REG_SRC_WIDTH, 2, width of the ring source-ID field.
- REG_ADDR_WIDTH, 23, ring address width.
- REG_DATA_WIDTH, 32, ring data width.
- TAG_WIDTH, 17, number of address MSBs compared against TAG.
- TAG, 0, block tag this node claims.
- NUM_COUNTERS, 4, hardware counters (1..8); occupy word indices 0..NUM_COUNTERS-1.
- NUM_SW_REGS, 4, software registers (1..8); occupy indices NUM_COUNTERS..NUM_COUNTERS+NUM_SW_REGS-1.
- SW_REG_RESET, 0, reset value of every software register.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- reg_req_in  in  1  ring request valid.
- reg_ack_in  in  1  request already answered upstream.
- reg_rd_wr_L_in  in  1  1 = read, 0 = write.
- reg_addr_in  in  REG_ADDR_WIDTH  word address.
- reg_data_in  in  REG_DATA_WIDTH  write data, or read data if already acked.
- reg_src_in  in  UDP_REG_SRC_WIDTH  source ID.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out  out  same widths  ring outputs to next node.
- counter_inc  in  NUM_COUNTERS  one-cycle increment pulse per counter.
- sw_regs  out  NUM_SW_REGS*REG_DATA_WIDTH  software register values; reg k in bits [k*32+31:k*32].

Behaviour:
- Reset, asynchronous and active-high:
  - all ring outputs 0;
  - all counters 0;
  - all sw_regs = SW_REG_RESET.
- Ring path:
  - every ring output is registered, with exactly 1-cycle latency from input to output;
  - no backpressure; the node accepts one ring word per cycle.
- Claim condition: reg_req_in=1 AND reg_ack_in=0 AND reg_addr_in[REG_ADDR_WIDTH-1 -: TAG_WIDTH]==TAG.
- Not claimed: all fields are forwarded unchanged next cycle. This includes requests with ack_in=1 and cycles with req_in=0.
- Claimed: next cycle, reg_req_out=1, reg_ack_out=1, and addr/src/rd_wr_L are forwarded.
- Index = addr low bits, with width REG_ADDR_WIDTH-TAG_WIDTH.
- Read:
  - reg_data_out = counter[index] if index < NUM_COUNTERS;
  - otherwise the software register at index-NUM_COUNTERS if in range;
  - otherwise 32'hDEAD_BEEF.
- Write:
  - to a software register, the register updates at the same edge the ack is registered; sw_regs reflects the new value 1 cycle after the request;
  - to a counter or an out-of-range index, the write is acked and ignored;
  - reg_data_out = reg_data_in on all writes.
- Counters:
  - 32-bit, increment by 1 on each counter_inc[i]=1 cycle;
  - wrap from 32'hFFFF_FFFF to 0;
  - a read returns the value before that cycle's increment.
- Back-to-back claimed requests on consecutive cycles are each served independently; there is no hazard, because a write is visible to a read issued on the next cycle.
- Reset asserted mid-transaction: the in-flight request is dropped, and ring outputs are 0 while reset is held.

Optional Feature:
- Macro: UDP_REG_RESPONDER_CLR_ON_READ_EN.
- Defined:
  - a claimed read of counter i returns its current value and clears it in the same cycle;
  - if counter_inc[i]=1 in that cycle, the counter becomes 1, not 0, so no event is lost.
- Undefined: counter reads are non-destructive.

Test Plan:
- Reset, then read index 0 with TAG match → next cycle ack_out=1, data_out=0; sw_regs all SW_REG_RESET.
- Write 32'h1234_5678 to index NUM_COUNTERS, then read it → read data 32'h1234_5678; sw_regs[31:0]=32'h1234_5678 one cycle after the write.
- Pulse counter_inc[2] 5 times, then read index 2 → 5. With the CLR macro, a second read returns 0, and a read coincident with an increment leaves the counter at 1.
- Request with tag mismatch, and a request with ack_in=1 and data 32'hCAFE_0000 → both forwarded unchanged with 1-cycle latency; no sw_reg change.
- Read index NUM_COUNTERS+NUM_SW_REGS (out of range) → ack_out=1, data 32'hDEAD_BEEF. Write to counter index 1 → acked, counter unchanged.
- Preload counter 0 to 32'hFFFF_FFFF via increments, apply one more inc → reads 0. Assert reset mid-request → outputs 0 asynchronously.
